// File: rtl/mcp3_req512.sv
// 512-slot pending-request tracker with an incremental population count and a one-deep grant register.
// Optional build macro: MCP3_REQ512_COLLISION_CHK_EN enables the set_collision pulse.

module mcp3_req512_slot (
  input  logic clock,
  input  logic reset,
  input  logic set_en,
  input  logic clr_en,
  output logic pend
);
  // Set wins over clear so that a re-post in the grant cycle is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      pend <= 1'b0;
    else if (set_en) pend <= 1'b1;
    else if (clr_en) pend <= 1'b0;
  end
endmodule

module mcp3_req512 #(
  parameter int NUM_SLOTS = 512,
  parameter int IDX_W     = $clog2(NUM_SLOTS),
  parameter int CNT_W     = $clog2(NUM_SLOTS) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [IDX_W-1:0]     set_index,
  output logic [NUM_SLOTS-1:0] req_bus,
  input  logic [NUM_SLOTS-1:0] req_clear,
  input  logic                 final_valid,
  input  logic [IDX_W-1:0]     final_winner,
  output logic                 req_taken,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_index,
  input  logic                 grant_ready,
  output logic [CNT_W-1:0]     pending_count,
  output logic                 set_collision
);
  logic [NUM_SLOTS-1:0] set_mask;
  logic                 slot_pend;
  logic                 set_new;
  logic                 clr_hit;

  assign set_mask  = set_valid ? (NUM_SLOTS'(1) << set_index) : '0;
  assign slot_pend = req_bus[set_index];
  assign set_new   = set_valid & ~slot_pend;
  // A clear masked by a coincident set of the same slot does not count.
  assign clr_hit   = |(req_clear & req_bus & ~set_mask);

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    mcp3_req512_slot u_slot (
      .clock  (clock),
      .reset  (reset),
      .set_en (set_mask[s]),
      .clr_en (req_clear[s]),
      .pend   (req_bus[s])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_count <= '0;
    end else begin
      case ({set_new, clr_hit})
        2'b10:   pending_count <= pending_count + CNT_W'(1);
        2'b01:   pending_count <= pending_count - CNT_W'(1);
        default: pending_count <= pending_count;
      endcase
    end
  end

`ifdef MCP3_REQ512_COLLISION_CHK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) set_collision <= 1'b0;
    else        set_collision <= set_valid & slot_pend;
  end
`else
  assign set_collision = 1'b0;
`endif

  // Reset gates the handshake so nothing is accepted while the block is held.
  assign req_taken = reset & final_valid & (~grant_valid | grant_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_valid <= 1'b0;
      grant_index <= '0;
    end else if (req_taken) begin
      grant_valid <= 1'b1;
      grant_index <= final_winner;
    end else if (grant_ready) begin
      grant_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mcp3_req512.sv
// Scoreboard bench for mcp3_req512: a behavioural model pushes expected state per driven cycle,
// a monitor pops and compares after each rising edge.

module tb_mcp3_req512;
  logic         clock = 1'b0;
  logic         reset;
  logic         set_valid;
  logic [8:0]   set_index;
  logic [511:0] req_bus;
  logic [511:0] req_clear;
  logic         final_valid;
  logic [8:0]   final_winner;
  logic         req_taken;
  logic         grant_valid;
  logic [8:0]   grant_index;
  logic         grant_ready;
  logic [9:0]   pending_count;
  logic         set_collision;

  mcp3_req512 dut (
    .clock         (clock),
    .reset         (reset),
    .set_valid     (set_valid),
    .set_index     (set_index),
    .req_bus       (req_bus),
    .req_clear     (req_clear),
    .final_valid   (final_valid),
    .final_winner  (final_winner),
    .req_taken     (req_taken),
    .grant_valid   (grant_valid),
    .grant_index   (grant_index),
    .grant_ready   (grant_ready),
    .pending_count (pending_count),
    .set_collision (set_collision)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] bus;
    int           cnt;
    logic         coll;
    logic         gv;
    logic [8:0]   gi;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_err    = 0;
  logic [511:0] m_bus;
  logic         m_gv;
  logic [8:0]   m_gi;
  logic         exp_taken;

  function automatic logic [511:0] onehot(input logic [8:0] idx);
    logic [511:0] one;
    one = 512'd1;
    return one << idx;
  endfunction

  // Drives one cycle of stimulus at the falling edge and pushes the expected post-edge state.
  task automatic drive(input logic sv, input logic [8:0] si, input logic [511:0] clr,
                       input logic fv, input logic [8:0] fw, input logic gr);
    exp_t e;
    @(negedge clock);
    set_valid = sv; set_index = si; req_clear = clr;
    final_valid = fv; final_winner = fw; grant_ready = gr;
`ifdef MCP3_REQ512_COLLISION_CHK_EN
    e.coll = sv & m_bus[si];
`else
    e.coll = 1'b0;
`endif
    m_bus = m_bus & ~clr;
    if (sv) m_bus[si] = 1'b1;
    exp_taken = fv & (~m_gv | gr);
    if (exp_taken) begin m_gv = 1'b1; m_gi = fw; end
    else if (gr)   m_gv = 1'b0;
    e.bus = m_bus; e.cnt = $countones(m_bus); e.gv = m_gv; e.gi = m_gi;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    set_valid = 0; set_index = 0; req_clear = '0;
    final_valid = 0; final_winner = 0; grant_ready = 0;
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_checks++;
      if (req_bus !== mon_e.bus) begin
        n_err++; $display("FAIL req_bus got %h exp %h", req_bus, mon_e.bus);
      end
      n_checks++;
      if (pending_count !== 10'(mon_e.cnt)) begin
        n_err++; $display("FAIL pending_count got %0d exp %0d", pending_count, mon_e.cnt);
      end
      n_checks++;
      if (set_collision !== mon_e.coll) begin
        n_err++; $display("FAIL set_collision got %b exp %b", set_collision, mon_e.coll);
      end
      n_checks++;
      if (grant_valid !== mon_e.gv) begin
        n_err++; $display("FAIL grant_valid got %b exp %b", grant_valid, mon_e.gv);
      end
      n_checks++;
      if (grant_index !== mon_e.gi) begin
        n_err++; $display("FAIL grant_index got %h exp %h", grant_index, mon_e.gi);
      end
    end
  end

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    m_bus = '0; m_gv = 0; m_gi = 0;
    repeat (3) @(posedge clock);
    #2;
    n_checks++;
    if (req_bus !== '0 || pending_count !== 10'd0 || grant_valid !== 1'b0 ||
        grant_index !== 9'd0 || set_collision !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state bus_nz=%b cnt=%0d gv=%b gi=%h coll=%b",
               |req_bus, pending_count, grant_valid, grant_index, set_collision);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_post_set();
    drive(1, 9'd5, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_same_slot();
    drive(1, 9'd300, '0, 0, 0, 0);
    drive(1, 9'd300, onehot(9'd300), 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0);
    drive(0, 0, onehot(9'd300), 0, 0, 0);
  endtask

  task automatic test_clear_paths();
    drive(0, 0, onehot(9'd7), 0, 0, 0);
    drive(1, 9'd20, onehot(9'd5), 0, 0, 0);
    drive(1, 9'd21, '0, 0, 0, 0);
    drive(0, 0, onehot(9'd20), 0, 0, 0);
    drive(1, 9'd21, onehot(9'd100), 0, 0, 0);
  endtask

  task automatic test_backpressure();
    drive(1, 9'd50, '0, 1, 9'h1A3, 0);
    #1;
    n_checks++;
    if (req_taken !== 1'b1) begin n_err++; $display("FAIL bp_first_taken got %b exp 1", req_taken); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 1, 9'h055, 0);
      #1;
      n_checks++;
      if (req_taken !== 1'b0) begin n_err++; $display("FAIL bp_hold_taken got %b exp 0", req_taken); end
    end
    drive(0, 0, '0, 1, 9'h055, 1);
    #1;
    n_checks++;
    if (req_taken !== 1'b1) begin n_err++; $display("FAIL bp_release_taken got %b exp 1", req_taken); end
    drive(0, 0, '0, 0, 0, 1);
    drive(0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [8:0] w;
    for (int i = 0; i < 4; i++) begin
      w = 9'(i * 128);
      drive(0, 0, '0, 1, w, 1);
      #1;
      n_checks++;
      if (req_taken !== 1'b1) begin n_err++; $display("FAIL b2b_taken[%0d] got %b exp 1", i, req_taken); end
    end
    drive(0, 0, '0, 0, 0, 1);
  endtask

  task automatic test_full();
    for (int i = 0; i < 512; i++) drive(1, 9'(i), '0, 0, 0, 0);
    drive(1, 9'd77, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0);
    @(posedge clock); #2;
    n_checks++;
    if (pending_count !== 10'd512) begin
      n_err++; $display("FAIL full_count got %0d exp 512", pending_count);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    for (int i = 0; i < 10; i++) drive(1, 9'(i * 37), '0, 0, 0, 0);
    drive(0, 0, '0, 1, 9'h0F0, 0);
    drive(0, 0, '0, 1, 9'h0F1, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_bus !== '0 || pending_count !== 10'd0 || grant_valid !== 1'b0 ||
        grant_index !== 9'd0 || set_collision !== 1'b0 || req_taken !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid bus_nz=%b cnt=%0d gv=%b gi=%h coll=%b taken=%b",
               |req_bus, pending_count, grant_valid, grant_index, set_collision, req_taken);
    end
    m_bus = '0; m_gv = 0; m_gi = 0;
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    drive(1, 9'd511, '0, 1, 9'h1FF, 1);
    drive(0, 0, '0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_post_set();
    test_same_slot();
    test_clear_paths();
    test_backpressure();
    test_back_to_back();
    test_full();
    test_reset_mid();
    @(posedge clock); #3;
    n_checks++;
    if (q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain left %0d exp 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mcp3_req512.md
MCP3_REQ512 -- requirements
Module: mcp3_req512

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port set_valid, input, 1, a new request is posted this cycle.
REQ-004 SHALL have port set_index, input, 9, slot number (0-511) of the new request; qualified by set_valid.
REQ-005 SHALL have port req_bus, output, 512, registered pending-request vector driven to the 512-way arbiter.
REQ-006 SHALL have port req_clear, input, 512, one-hot (or zero) clear from the arbiter for the slot just granted.
REQ-007 SHALL have port final_valid, input, 1, arbiter has a winner.
REQ-008 SHALL have port final_winner, input, 9, encoded winning slot; qualified by final_valid.
REQ-009 SHALL have port req_taken, output, 1, winner accepted this cycle (combinational).
REQ-010 SHALL have port grant_valid, output, 1, registered grant available downstream.
REQ-011 SHALL have port grant_index, output, 9, registered granted slot number.
REQ-012 SHALL have port grant_ready, input, 1, downstream consumes the grant this cycle.
REQ-013 SHALL have port pending_count, output, 10, registered number of set bits in req_bus (0-512).
REQ-014 SHALL have port set_collision, output, 1, registered one-cycle pulse: set_valid hit an already-pending slot.

Function
REQ-015 SHALL compute next pending = (req_bus & ~req_clear) | onehot(set_index) when set_valid, else req_bus & ~req_clear; req_bus updates one cycle after set/clear.
REQ-016 SHALL give set priority over clear when both target the same slot in one cycle: bit stays 1.
REQ-017 SHALL ignore req_clear bits whose slot is not pending (no count change, no error).
REQ-018 SHALL update pending_count incrementally: +1 if set_valid and slot not pending; -1 if req_clear hits a pending slot not also being set; net 0 when both occur on different slots.
REQ-019 SHALL leave req_bus and pending_count unchanged when set_valid hits an already-pending slot, with or without a coincident clear of that slot.
REQ-020 SHALL treat multi-hot req_clear as illegal input; bits are still cleared, and pending_count is then undefined until reset.
REQ-021 SHALL drive req_taken = final_valid & (~grant_valid | grant_ready); there is no pipeline bubble.
REQ-022 SHALL, when req_taken, load grant_index <= final_winner and set grant_valid <= 1 on the next edge.
REQ-023 SHALL, when grant_valid & grant_ready & ~req_taken, clear grant_valid on the next edge; grant_index holds its last value.
REQ-024 SHALL hold grant_valid and grant_index stable while grant_valid & ~grant_ready, and keep req_taken at 0 during that time.
REQ-025 SHALL saturate nothing: pending_count reaches exactly 512 when all slots are pending; a further set is a collision.

Reset
REQ-026 SHALL, on reset low, asynchronously force req_bus=0, pending_count=0, grant_valid=0, grant_index=0 and set_collision=0.
REQ-027 SHALL discard pending requests and any held grant when reset asserts mid-operation; req_taken=0 while reset is low.
REQ-028 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Configuration
REQ-029 SHALL, with MCP3_REQ512_COLLISION_CHK_EN defined, pulse set_collision high for one cycle, on the cycle after set_valid targets a slot already pending in req_bus.
REQ-030 SHALL, without MCP3_REQ512_COLLISION_CHK_EN, tie set_collision to constant 0 and include no collision logic; REQ-019 behaviour is unchanged.

Verification
REQ-031 SHALL cover post-set: reset release; set_valid with set_index=5 -> next cycle req_bus[5]=1 and pending_count=1.
REQ-032 SHALL cover same-slot set and clear: slot 300 pending; set_index=300 with req_clear[300]=1 in the same cycle -> req_bus[300]=1, count unchanged, set_collision=1 when the macro is defined, else 0.
REQ-033 SHALL cover grant backpressure: final_valid=1, final_winner=0x1A3, grant_ready=0 -> req_taken=1 once, then grant_valid=1 and grant_index=0x1A3; req_taken stays 0 until grant_ready=1.
REQ-034 SHALL cover back-to-back grants: grant_ready=1 and final_valid=1 for 4 cycles with winners 0,128,256,384 -> req_taken=1 every cycle and grant_index follows with 1-cycle latency.
REQ-035 SHALL cover the full condition: set all 512 slots -> pending_count=512; one more set -> count stays 512 and a collision pulse is produced.
REQ-036 SHALL cover reset mid-operation: reset low with 10 pending and grant_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
